// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer
//  Purpose  : Sequences one DSP48A1 slice as a multiply-accumulate engine for
//             dot products. A command carries the element count. Operand
//             pairs are then streamed into the slice A/B registers, and a tag
//             pipeline that matches the slice's A0/A1/M latency steers CEP
//             and OPMODE so that the first product loads P (Z=0) and later
//             products accumulate (Z=P). The final P value is returned on a
//             valid/ready result port.
//  Slice    : A0/A1, B0/B1, M and P registers enabled, OPMODEREG=0.
//  Ports    : clk, rst_n (async, active low)
//             cmd_valid/cmd_ready/cmd_len      - command handshake
//             op_valid/op_ready/op_a/op_b      - operand pair stream
//             res_valid/res_ready/res_data     - result handshake
//             dsp_a/dsp_b, dsp_cea/ceb/cem/cep,
//             dsp_opmode, dsp_p                - DSP48A1 slice interface
//  Option   : DSP_MAC_SEQ_PREADD_EN adds op_d/dsp_d, cmd_presub and dsp_ced,
//             and routes products through the pre-adder as (D +/- B) * A.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int LEN_WIDTH = 8,
  // Must be at least 2: one tag stage plus the registered CEP/OPMODE stage.
  parameter int M_LAT     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Command
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_len,
`ifdef DSP_MAC_SEQ_PREADD_EN
  input  logic                 cmd_presub,
`endif
  // Operand stream
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [A_WIDTH-1:0]   op_a,
  input  logic [B_WIDTH-1:0]   op_b,
`ifdef DSP_MAC_SEQ_PREADD_EN
  input  logic [B_WIDTH-1:0]   op_d,
`endif
  // Result
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [P_WIDTH-1:0]   res_data,
  // DSP48A1 slice
  output logic [A_WIDTH-1:0]   dsp_a,
  output logic [B_WIDTH-1:0]   dsp_b,
`ifdef DSP_MAC_SEQ_PREADD_EN
  output logic [B_WIDTH-1:0]   dsp_d,
  output logic                 dsp_ced,
`endif
  output logic                 dsp_cea,
  output logic                 dsp_ceb,
  output logic                 dsp_cem,
  output logic                 dsp_cep,
  output logic [7:0]           dsp_opmode,
  input  logic [P_WIDTH-1:0]   dsp_p
);

  // The last tag stage is the registered CEP/OPMODE pair itself, so the
  // shift register in front of it is one stage shorter than M_LAT.
  localparam int TAG_DEPTH = M_LAT - 1;

  // X=M, Z=0 loads the first product; X=M, Z=P accumulates (and holds P
  // when CEP is low).
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [TAG_DEPTH-1:0]  r_tag_valid;
  logic [TAG_DEPTH-1:0]  r_tag_first;
  logic                  r_exit_seen;

  logic                  w_cmd_acc;
  logic                  w_op_acc;
  logic                  w_res_acc;
  logic [LEN_WIDTH-1:0]  w_count_inc;
  logic                  w_last_op;
  logic                  w_first_op;
  logic                  w_out_valid;
  logic                  w_out_first;
  logic                  w_pipe_empty;
  logic [TAG_DEPTH-1:0]  w_tag_valid_shift;
  logic [TAG_DEPTH-1:0]  w_tag_first_shift;
  logic [7:0]            w_preadd_bits;

  assign w_cmd_acc   = cmd_valid & cmd_ready;
  assign w_op_acc    = op_valid & op_ready;
  assign w_res_acc   = res_valid & res_ready;
  assign w_count_inc = r_count + LEN_WIDTH'(1);
  assign w_last_op   = (w_count_inc == r_len);
  assign w_first_op  = (r_count == '0);

  // Oldest tag, about to become the CEP/OPMODE of the cycle in which its
  // product sits at the post-adder X input.
  assign w_out_valid = r_tag_valid[TAG_DEPTH-1];
  assign w_out_first = r_tag_first[TAG_DEPTH-1];

  // Nothing left in flight: neither queued tags nor a P update this cycle.
  assign w_pipe_empty = ~(|r_tag_valid) & ~dsp_cep;

  // Operand path is a straight wire; the slice registers do the capture.
  assign dsp_a   = op_a;
  assign dsp_b   = op_b;
  assign dsp_cea = w_op_acc;
  assign dsp_ceb = w_op_acc;
  assign dsp_cem = 1'b1;

  // Tag shift register input: a bubble shifts in an invalid tag.
  generate
    if (TAG_DEPTH > 1) begin : g_tag_shift
      assign w_tag_valid_shift = {r_tag_valid[TAG_DEPTH-2:0], w_op_acc};
      assign w_tag_first_shift = {r_tag_first[TAG_DEPTH-2:0], w_op_acc & w_first_op};
    end else begin : g_tag_single
      assign w_tag_valid_shift = w_op_acc;
      assign w_tag_first_shift = w_op_acc & w_first_op;
    end
  endgenerate

`ifdef DSP_MAC_SEQ_PREADD_EN
  logic r_presub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presub <= 1'b0;
    end else if (w_cmd_acc) begin
      r_presub <= cmd_presub;
    end
  end

  assign dsp_d   = op_d;
  assign dsp_ced = w_op_acc;
  // Bit 4 selects the pre-adder into the multiplier, bit 6 makes it subtract.
  assign w_preadd_bits = {1'b0, r_presub, 1'b0, 1'b1, 4'b0000};
`else
  assign w_preadd_bits = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_tag_valid <= '0;
      r_tag_first <= '0;
      r_exit_seen <= 1'b0;
      cmd_ready   <= 1'b1;
      op_ready    <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      dsp_cep     <= 1'b0;
      dsp_opmode  <= 8'h00;
    end else begin
      // Tag pipeline runs every cycle regardless of state.
      r_tag_valid <= w_tag_valid_shift;
      r_tag_first <= w_tag_first_shift;
      dsp_cep     <= w_out_valid;
      if (w_out_valid) begin
        dsp_opmode <= (w_out_first ? OPM_FIRST : OPM_ACC) | w_preadd_bits;
      end else begin
        dsp_opmode <= OPM_ACC;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            r_len     <= cmd_len;
            r_count   <= '0;
            cmd_ready <= 1'b0;
            if (cmd_len == '0) begin
              // Empty dot product: answer directly, the slice is not used.
              res_data  <= '0;
              res_valid <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              op_ready <= 1'b1;
              r_state  <= ST_STREAM;
            end
          end
        end

        ST_STREAM: begin
          if (w_op_acc) begin
            r_count <= w_count_inc;
            if (w_last_op) begin
              op_ready <= 1'b0;
              r_state  <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // Once the pipe is seen empty, P has already taken the last
          // product; sample it on the following edge.
          if (r_exit_seen) begin
            res_data    <= dsp_p;
            res_valid   <= 1'b1;
            r_exit_seen <= 1'b0;
            r_state     <= ST_DONE;
          end else if (w_pipe_empty) begin
            r_exit_seen <= 1'b1;
          end
        end

        ST_DONE: begin
          if (w_res_acc) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mac_sequencer
//  Purpose  : Self-checking bench for dsp_mac_sequencer. A behavioural
//             DSP48A1 slice (product delay line plus P register driven by
//             CEP/OPMODE) closes the loop; expected dot products come from
//             plain integer arithmetic over the stimulus arrays.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;

  localparam int A_WIDTH   = 18;
  localparam int B_WIDTH   = 18;
  localparam int P_WIDTH   = 48;
  localparam int LEN_WIDTH = 8;
  localparam int M_LAT     = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 op_valid;
  logic                 op_ready;
  logic [A_WIDTH-1:0]   op_a;
  logic [B_WIDTH-1:0]   op_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [P_WIDTH-1:0]   res_data;
  logic [A_WIDTH-1:0]   dsp_a;
  logic [B_WIDTH-1:0]   dsp_b;
  logic                 dsp_cea;
  logic                 dsp_ceb;
  logic                 dsp_cem;
  logic                 dsp_cep;
  logic [7:0]           dsp_opmode;
  logic [P_WIDTH-1:0]   dsp_p = '0;
`ifdef DSP_MAC_SEQ_PREADD_EN
  logic                 cmd_presub;
  logic [B_WIDTH-1:0]   op_d;
  logic [B_WIDTH-1:0]   dsp_d;
  logic                 dsp_ced;
`endif

  dsp_mac_sequencer #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .P_WIDTH  (P_WIDTH),
    .LEN_WIDTH(LEN_WIDTH),
    .M_LAT    (M_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
`ifdef DSP_MAC_SEQ_PREADD_EN
    .cmd_presub(cmd_presub),
`endif
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef DSP_MAC_SEQ_PREADD_EN
    .op_d      (op_d),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
`ifdef DSP_MAC_SEQ_PREADD_EN
    .dsp_d     (dsp_d),
    .dsp_ced   (dsp_ced),
`endif
    .dsp_cea   (dsp_cea),
    .dsp_ceb   (dsp_ceb),
    .dsp_cem   (dsp_cem),
    .dsp_cep   (dsp_cep),
    .dsp_opmode(dsp_opmode),
    .dsp_p     (dsp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural slice ----------------
  logic signed [A_WIDTH-1:0] sa;
  logic signed [B_WIDTH-1:0] sb;
  logic signed [B_WIDTH-1:0] sd;
  assign sa = dsp_a;
  assign sb = dsp_b;
`ifdef DSP_MAC_SEQ_PREADD_EN
  assign sd = dsp_d;
`else
  assign sd = '0;
`endif

  longint             lp_plain, lp_add, lp_sub;
  logic [P_WIDTH-1:0] pr_plain, pr_add, pr_sub, x_sel, z_sel;
  logic [P_WIDTH-1:0] xp_plain [M_LAT];
  logic [P_WIDTH-1:0] xp_add   [M_LAT];
  logic [P_WIDTH-1:0] xp_sub   [M_LAT];

  always_comb begin
    lp_plain = longint'(sa) * longint'(sb);
    lp_add   = (longint'(sd) + longint'(sb)) * longint'(sa);
    lp_sub   = (longint'(sd) - longint'(sb)) * longint'(sa);
    pr_plain = lp_plain[P_WIDTH-1:0];
    pr_add   = lp_add[P_WIDTH-1:0];
    pr_sub   = lp_sub[P_WIDTH-1:0];
    x_sel = '0;
    if (dsp_opmode[1:0] == 2'b01)
      x_sel = dsp_opmode[4] ? (dsp_opmode[6] ? xp_sub[M_LAT-1] : xp_add[M_LAT-1])
                            : xp_plain[M_LAT-1];
    z_sel = (dsp_opmode[3:2] == 2'b10) ? dsp_p : '0;
  end

  // A product is at X exactly M_LAT edges after its accept edge.
  always @(posedge clk) begin
    if (dsp_cep) dsp_p <= z_sel + x_sel;
    xp_plain[0] <= dsp_cea ? pr_plain : '0;
    xp_add[0]   <= dsp_cea ? pr_add   : '0;
    xp_sub[0]   <= dsp_cea ? pr_sub   : '0;
    for (int i = 1; i < M_LAT; i++) begin
      xp_plain[i] <= xp_plain[i-1];
      xp_add[i]   <= xp_add[i-1];
      xp_sub[i]   <= xp_sub[i-1];
    end
  end

  // Log of OPMODE on every cycle where P is enabled.
  logic [7:0] opm_log [$];
  always @(negedge clk) if (dsp_cep) opm_log.push_back(dsp_opmode);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Job stimulus: operands, gaps before each operand, presub flag.
  int ja [0:15];
  int jb [0:15];
  int jd [0:15];
  int jg [0:15];
  int jpresub;

  function automatic logic [P_WIDTH-1:0] ref_dot(input int len);
    longint sum;
    sum = 0;
    for (int i = 0; i < len; i++) begin
`ifdef DSP_MAC_SEQ_PREADD_EN
      if (jpresub != 0) sum += (longint'(jd[i]) - longint'(jb[i])) * longint'(ja[i]);
      else              sum += (longint'(jd[i]) + longint'(jb[i])) * longint'(ja[i]);
`else
      sum += longint'(ja[i]) * longint'(jb[i]);
`endif
    end
    return sum[P_WIDTH-1:0];
  endfunction

  function automatic logic [7:0] extra_bits();
`ifdef DSP_MAC_SEQ_PREADD_EN
    return 8'h10 | ((jpresub != 0) ? 8'h40 : 8'h00);
`else
    return 8'h00;
`endif
  endfunction

  task automatic run_job(input string name, input int len, input int hold);
    logic [P_WIDTH-1:0] exp_res;
    logic [P_WIDTH-1:0] held;
    logic [7:0]         exp_opm;
    int  t, base, n, cmd_edge, acc_edge, rv_cyc, exp_rv;
    bit  stable;
    exp_res = ref_dot(len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LEN_WIDTH'(len);
`ifdef DSP_MAC_SEQ_PREADD_EN
    cmd_presub = (jpresub != 0);
`endif
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check({name, ":cmd_timeout"}, 64'(t >= 100), 64'd0);
    cmd_edge = cyc + 1;
    acc_edge = cmd_edge;
    base     = opm_log.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      op_valid = 1'b0;
      repeat (jg[i]) @(negedge clk);
      op_valid = 1'b1;
      op_a = A_WIDTH'(ja[i]);
      op_b = B_WIDTH'(jb[i]);
`ifdef DSP_MAC_SEQ_PREADD_EN
      op_d = B_WIDTH'(jd[i]);
`endif
      t = 0;
      while (!op_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) check({name, ":op_timeout"}, 64'd1, 64'd0);
      acc_edge = cyc + 1;
      @(negedge clk);
    end
    op_valid = 1'b0;
    res_ready = 1'b0;
    t = 0;
    while (!res_valid && t < 300) begin @(negedge clk); t++; end
    check({name, ":res_timeout"}, 64'(t >= 300), 64'd0);
    rv_cyc = cyc;
    exp_rv = (len == 0) ? cmd_edge : acc_edge + M_LAT + 2;
    check({name, ":latency"}, 64'(rv_cyc), 64'(exp_rv));
    check({name, ":res_data"}, 64'(res_data), 64'(exp_res));
    n = opm_log.size() - base;
    check({name, ":cep_count"}, 64'(n), 64'(len));
    for (int i = 0; i < n && i < len; i++) begin
      exp_opm = ((i == 0) ? 8'h01 : 8'h09) | extra_bits();
      check({name, ":opmode"}, 64'(opm_log[base + i]), 64'(exp_opm));
    end
    if (hold > 0) begin
      stable = 1'b1;
      held   = res_data;
      repeat (hold) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_data !== held || cmd_ready !== 1'b0) stable = 1'b0;
      end
      check({name, ":hold_stable"}, 64'(stable), 64'd1);
      check({name, ":hold_data"}, 64'(res_data), 64'(exp_res));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, ":rv_clear"}, 64'(res_valid), 64'd0);
    check({name, ":cmd_ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0; jpresub = 0;
`ifdef DSP_MAC_SEQ_PREADD_EN
    cmd_presub = 1'b0; op_d = '0;
`endif
    for (int i = 0; i < 16; i++) begin ja[i] = 0; jb[i] = 0; jd[i] = 0; jg[i] = 0; end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst:cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst:op_ready", 64'(op_ready), 64'd0);
    check("rst:res_valid", 64'(res_valid), 64'd0);
    check("rst:res_data", 64'(res_data), 64'd0);
    check("rst:cep", 64'(dsp_cep), 64'd0);
    check("rst:opmode", 64'(dsp_opmode), 64'h00);
    check("rst:cem", 64'(dsp_cem), 64'd1);
    rst_n = 1'b1;

    // Operands outside STREAM are ignored
    op_valid = 1'b1; op_a = 18'h00123; op_b = 18'h00045;
    @(negedge clk);
    check("idle:op_ready", 64'(op_ready), 64'd0);
    check("idle:cea", 64'(dsp_cea), 64'd0);
    check("idle:dsp_a", 64'(dsp_a), 64'h123);
    op_valid = 1'b0;

    // Reset in the middle of a stream
    cmd_valid = 1'b1; cmd_len = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0; op_valid = 1'b1; op_a = 18'd7; op_b = 18'd9;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; op_valid = 1'b0;
    #1;
    check("midrst:cep", 64'(dsp_cep), 64'd0);
    check("midrst:op_ready", 64'(op_ready), 64'd0);
    check("midrst:cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    base = opm_log.size();
    repeat (8) @(negedge clk);
    check("midrst:no_cep", 64'(opm_log.size() - base), 64'd0);
    ja[0] = 1; jb[0] = 1; jd[0] = 0; jg[0] = 0;
    ja[1] = 2; jb[1] = 2; jd[1] = 0; jg[1] = 0;
    run_job("after_rst", 2, 0);

    // Directed: three elements, no bubbles, result held 10 cycles
    ja[0] = 2;  jb[0] = 3; jg[0] = 0;
    ja[1] = 4;  jb[1] = 5; jg[1] = 0;
    ja[2] = -1; jb[2] = 7; jg[2] = 0;
    for (int i = 0; i < 3; i++) jd[i] = 0;
    run_job("len3", 3, 10);

    // Directed: bubbles between operands
    ja[0] = 10; jb[0] = 10; jg[0] = 0;
    ja[1] = 3;  jb[1] = -4; jg[1] = 2;
    run_job("bubbles", 2, 0);

    // Directed: empty command
    run_job("len0", 0, 0);

`ifdef DSP_MAC_SEQ_PREADD_EN
    // Pre-adder: (5 + 2) * 3
    jpresub = 0; ja[0] = 3; jb[0] = 2; jd[0] = 5; jg[0] = 0;
    run_job("preadd", 1, 0);
    jpresub = 1;
    run_job("presub", 1, 0);
`endif

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      len = int'($urandom_range(1, 8));
`ifdef DSP_MAC_SEQ_PREADD_EN
      jpresub = int'($urandom_range(0, 1));
`endif
      for (int i = 0; i < len; i++) begin
        ja[i] = int'($urandom_range(0, 262143)) - 131072;
`ifdef DSP_MAC_SEQ_PREADD_EN
        jb[i] = int'($urandom_range(0, 131071)) - 65536;
        jd[i] = int'($urandom_range(0, 131071)) - 65536;
`else
        jb[i] = int'($urandom_range(0, 262143)) - 131072;
        jd[i] = 0;
`endif
        jg[i] = int'($urandom_range(0, 2));
      end
      run_job("random", len, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
